// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Data-bus interface between the load/store unit and the data memory.
//
// Request channel (valid/ready): the master raises dmem_req_valid and holds
// dmem_addr/dmem_wen/dmem_wdata/dmem_wmask stable until the cycle in which
// dmem_req_ready is also high; that rising clock edge transfers the request.
// Response channel (valid only): the slave pulses dmem_rsp_valid for one cycle
// with dmem_rsp_rdata (whole aligned doubleword for reads, don't-care for
// write acknowledges); the master cannot back-pressure it.
//
// Signals:
//   dmem_req_valid  master->slave  request valid
//   dmem_req_ready  slave->master  request accepted
//   dmem_addr       master->slave  8-byte aligned address
//   dmem_wen        master->slave  1 = write, 0 = read
//   dmem_wdata      master->slave  lane-shifted store data
//   dmem_wmask      master->slave  lane-shifted byte mask
//   dmem_rsp_valid  slave->master  read data / write ack
//   dmem_rsp_rdata  slave->master  read doubleword
// -----------------------------------------------------------------------------
interface lsu_if;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [63:0] dmem_addr;
   logic        dmem_wen;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wmask;
   logic        dmem_rsp_valid;
   logic [63:0] dmem_rsp_rdata;

   modport master (
      output dmem_req_valid,
      input  dmem_req_ready,
      output dmem_addr,
      output dmem_wen,
      output dmem_wdata,
      output dmem_wmask,
      input  dmem_rsp_valid,
      input  dmem_rsp_rdata
   );

   modport slave (
      input  dmem_req_valid,
      output dmem_req_ready,
      input  dmem_addr,
      input  dmem_wen,
      input  dmem_wdata,
      input  dmem_wmask,
      output dmem_rsp_valid,
      output dmem_rsp_rdata
   );
endinterface

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Memory-stage load/store unit of the RV64 pipeline. Issues one data-bus
// request per load/store, stalls upstream while it is outstanding and
// registers the WB operands. WB does lane selection and sign/zero extension
// itself, so wb_mem_data is the raw bus doubleword and wb_byte_enable is the
// unshifted access size.
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to trap misaligned accesses
// (no bus request, wb_misalign=1, wb_rd_wena=0). Without it accesses are
// issued as-is (wmask truncated to the doubleword) and wb_misalign is 0.
//
// Ports:
//   clock, reset_n      clock (rising edge), asynchronous active-low reset
//   ex_*                EX/MEM slot: valid, ren/wen, ext_un, alu result /
//                       address, store data, byte enable, rd address/enable
//   mem_stall           combinational hold for EX/MEM and earlier stages
//   dmem                data-bus master (see lsu_if)
//   wb_*                registered WB operands
//   dbg_state           current FSM state (IDLE=0, REQ=1, WAIT_RSP=2)
// -----------------------------------------------------------------------------
module lsu (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ex_valid,
   input  logic        ex_mem_ren,
   input  logic        ex_mem_wen,
   input  logic        ex_mem_ext_un,
   input  logic [63:0] ex_alu_result,
   input  logic [63:0] ex_wdata,
   input  logic [7:0]  ex_byte_enable,
   input  logic [4:0]  ex_rd_waddr,
   input  logic        ex_rd_wena,
   output logic        mem_stall,
   lsu_if.master       dmem,
   output logic [63:0] wb_alu_result,
   output logic [63:0] wb_mem_data,
   output logic [7:0]  wb_byte_enable,
   output logic        wb_mem_to_reg,
   output logic        wb_mem_ext_un,
   output logic [4:0]  wb_rd_waddr,
   output logic        wb_rd_wena,
   output logic        wb_misalign,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   state_t state, state_next;

   // Copy of the memory op taken when it is accepted; the bus request and the
   // final WB write both come from here so upstream may change freely later.
   logic [63:0] lat_addr;
   logic [63:0] lat_wdata;
   logic [7:0]  lat_be;
   logic        lat_ext_un;
   logic [4:0]  lat_rd_waddr;
   logic        lat_rd_wena;
   logic        lat_is_store;
   logic        lat_en;

   logic [63:0] wb_alu_d;
   logic [63:0] wb_mem_data_d;
   logic [7:0]  wb_be_d;
   logic        wb_mem_to_reg_d;
   logic        wb_ext_un_d;
   logic [4:0]  wb_rd_waddr_d;
   logic        wb_rd_wena_d;
   logic        wb_misalign_d;

   logic is_mem;
   logic misaligned;

   assign is_mem = ex_mem_ren | ex_mem_wen;

`ifdef LSU_MISALIGN_CHECK_EN
   // Low address bits that must be zero for the access size; unknown
   // byte-enable encodings are treated as byte accesses.
   logic [2:0] size_mask;
   always_comb begin
      case (ex_byte_enable)
         8'h03:   size_mask = 3'd1;
         8'h0F:   size_mask = 3'd3;
         8'hFF:   size_mask = 3'd7;
         default: size_mask = 3'd0;
      endcase
   end
   assign misaligned = is_mem & (|(ex_alu_result[2:0] & size_mask));
`else
   assign misaligned = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, stall and WB operand selection
   always_comb begin
      state_next      = state;
      mem_stall       = 1'b0;
      lat_en          = 1'b0;
      wb_alu_d        = 64'd0;
      wb_mem_data_d   = 64'd0;
      wb_be_d         = 8'd0;
      wb_mem_to_reg_d = 1'b0;
      wb_ext_un_d     = 1'b0;
      wb_rd_waddr_d   = 5'd0;
      wb_rd_wena_d    = 1'b0;
      wb_misalign_d   = 1'b0;
      case (state)
         IDLE: begin
            if (ex_valid) begin
               if (is_mem && !misaligned) begin
                  mem_stall  = 1'b1;
                  lat_en     = 1'b1;
                  state_next = REQ;
               end else begin
                  // Plain ALU op, or a trapped misaligned access that
                  // retires straight to WB without touching the bus.
                  wb_alu_d        = ex_alu_result;
                  wb_be_d         = ex_byte_enable;
                  wb_mem_to_reg_d = ex_mem_ren;
                  wb_ext_un_d     = ex_mem_ext_un;
                  wb_rd_waddr_d   = ex_rd_waddr;
                  wb_rd_wena_d    = ex_rd_wena & ~misaligned;
                  wb_misalign_d   = misaligned;
               end
            end
         end
         REQ: begin
            mem_stall = 1'b1;
            if (dmem.dmem_req_ready) begin
               state_next = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (dmem.dmem_rsp_valid) begin
               wb_alu_d        = lat_addr;
               wb_mem_data_d   = lat_is_store ? 64'd0 : dmem.dmem_rsp_rdata;
               wb_be_d         = lat_be;
               wb_mem_to_reg_d = ~lat_is_store;
               wb_ext_un_d     = lat_ext_un;
               wb_rd_waddr_d   = lat_rd_waddr;
               wb_rd_wena_d    = lat_rd_wena;
               state_next      = IDLE;
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Latched memory op
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lat_addr     <= 64'd0;
         lat_wdata    <= 64'd0;
         lat_be       <= 8'd0;
         lat_ext_un   <= 1'b0;
         lat_rd_waddr <= 5'd0;
         lat_rd_wena  <= 1'b0;
         lat_is_store <= 1'b0;
      end else if (lat_en) begin
         lat_addr     <= ex_alu_result;
         lat_wdata    <= ex_wdata;
         lat_be       <= ex_byte_enable;
         lat_ext_un   <= ex_mem_ext_un;
         lat_rd_waddr <= ex_rd_waddr;
         lat_rd_wena  <= ex_rd_wena;
         lat_is_store <= ex_mem_wen;
      end
   end

   // WB operand registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wb_alu_result  <= 64'd0;
         wb_mem_data    <= 64'd0;
         wb_byte_enable <= 8'd0;
         wb_mem_to_reg  <= 1'b0;
         wb_mem_ext_un  <= 1'b0;
         wb_rd_waddr    <= 5'd0;
         wb_rd_wena     <= 1'b0;
         wb_misalign    <= 1'b0;
      end else begin
         wb_alu_result  <= wb_alu_d;
         wb_mem_data    <= wb_mem_data_d;
         wb_byte_enable <= wb_be_d;
         wb_mem_to_reg  <= wb_mem_to_reg_d;
         wb_mem_ext_un  <= wb_ext_un_d;
         wb_rd_waddr    <= wb_rd_waddr_d;
         wb_rd_wena     <= wb_rd_wena_d;
         wb_misalign    <= wb_misalign_d;
      end
   end

   // Request fields come only from the latched copy, so they are stable for
   // the whole REQ phase. The write mask is only meaningful for stores.
   assign dmem.dmem_req_valid = (state == REQ);
   assign dmem.dmem_addr      = {lat_addr[63:3], 3'b000};
   assign dmem.dmem_wen       = lat_is_store;
   assign dmem.dmem_wdata     = lat_wdata << {lat_addr[2:0], 3'b000};
   assign dmem.dmem_wmask     = lat_is_store ? (lat_be << lat_addr[2:0]) : 8'h00;

   assign dbg_state = state;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  `ifdef LSU_MISALIGN_CHECK_EN
  localparam bit misalign_chk = 1'b1;
  `else
  localparam bit misalign_chk = 1'b0;
  `endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        ex_valid = 1'b0;
  logic        ex_mem_ren = 1'b0;
  logic        ex_mem_wen = 1'b0;
  logic        ex_mem_ext_un = 1'b0;
  logic [63:0] ex_alu_result = '0;
  logic [63:0] ex_wdata = '0;
  logic [7:0]  ex_byte_enable = '0;
  logic [4:0]  ex_rd_waddr = '0;
  logic        ex_rd_wena = 1'b0;
  logic        mem_stall;
  logic [63:0] wb_alu_result;
  logic [63:0] wb_mem_data;
  logic [7:0]  wb_byte_enable;
  logic        wb_mem_to_reg;
  logic        wb_mem_ext_un;
  logic [4:0]  wb_rd_waddr;
  logic        wb_rd_wena;
  logic        wb_misalign;
  logic [1:0]  dbg_state;

  lsu_if dmem_bus ();

  lsu dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .ex_mem_ren     (ex_mem_ren),
    .ex_mem_wen     (ex_mem_wen),
    .ex_mem_ext_un  (ex_mem_ext_un),
    .ex_alu_result  (ex_alu_result),
    .ex_wdata       (ex_wdata),
    .ex_byte_enable (ex_byte_enable),
    .ex_rd_waddr    (ex_rd_waddr),
    .ex_rd_wena     (ex_rd_wena),
    .mem_stall      (mem_stall),
    .dmem           (dmem_bus),
    .wb_alu_result  (wb_alu_result),
    .wb_mem_data    (wb_mem_data),
    .wb_byte_enable (wb_byte_enable),
    .wb_mem_to_reg  (wb_mem_to_reg),
    .wb_mem_ext_un  (wb_mem_ext_un),
    .wb_rd_waddr    (wb_rd_waddr),
    .wb_rd_wena     (wb_rd_wena),
    .wb_misalign    (wb_misalign),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  // WB record: {alu64, mem_data64, be8, mem_to_reg, ext_un, rd5, wena, misalign}
  logic [144:0] exp_q[$];
  // Request record: {addr64, wen, wdata64, wmask8}
  logic [136:0] req_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference memory (byte image) ----------------
  logic [7:0]  ref_mem [logic [63:0]];
  logic [63:0] bus_mem [logic [60:0]];

  function automatic logic [7:0] init_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [63:0] ref_dword(input logic [63:0] base);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (ref_mem.exists(base + 64'(k))) r[8*k +: 8] = ref_mem[base + 64'(k)];
      else r[8*k +: 8] = init_byte(base + 64'(k));
    end
    return r;
  endfunction

  function automatic logic [63:0] bus_read(input logic [60:0] idx);
    logic [63:0] r;
    if (bus_mem.exists(idx)) return bus_mem[idx];
    r = '0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = init_byte({idx, 3'b000} + 64'(k));
    return r;
  endfunction

  task automatic poke(input logic [63:0] base, input logic [63:0] val);
    for (int k = 0; k < 8; k++) ref_mem[base + 64'(k)] = val[8*k +: 8];
    bus_mem[base[63:3]] = val;
  endtask

  // ---------------- bus responder ----------------
  int          cfg_rdy = 0;
  int          cfg_rsp = 0;
  bit          in_req = 1'b0;
  bit          rsp_pending = 1'b0;
  int          rdy_wait = 0;
  int          rsp_wait = 0;
  logic [63:0] rsp_data = '0;

  initial begin
    dmem_bus.dmem_req_ready = 1'b0;
    dmem_bus.dmem_rsp_valid = 1'b0;
    dmem_bus.dmem_rsp_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      dmem_bus.dmem_req_ready = 1'b0;
      dmem_bus.dmem_rsp_valid = 1'b0;
      dmem_bus.dmem_rsp_rdata = '0;
      if (rsp_pending) begin
        if (rsp_wait == 0) begin
          dmem_bus.dmem_rsp_valid = 1'b1;
          dmem_bus.dmem_rsp_rdata = rsp_data;
          rsp_pending = 1'b0;
        end else begin
          rsp_wait--;
        end
      end else if (dmem_bus.dmem_req_valid) begin
        if (!in_req) begin
          in_req = 1'b1;
          rdy_wait = cfg_rdy;
        end
        if (rdy_wait == 0) begin
          logic [63:0] d;
          dmem_bus.dmem_req_ready = 1'b1;
          in_req = 1'b0;
          rsp_pending = 1'b1;
          rsp_wait = cfg_rsp;
          d = bus_read(dmem_bus.dmem_addr[63:3]);
          if (dmem_bus.dmem_wen) begin
            for (int k = 0; k < 8; k++)
              if (dmem_bus.dmem_wmask[k]) d[8*k +: 8] = dmem_bus.dmem_wdata[8*k +: 8];
            bus_mem[dmem_bus.dmem_addr[63:3]] = d;
            rsp_data = '0;
          end else begin
            rsp_data = d;
          end
        end else begin
          rdy_wait--;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    if (reset_n && dmem_bus.dmem_req_valid) begin
      if (req_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected: got addr %h with no request expected", dmem_bus.dmem_addr);
      end else begin
        chk("req_fields", {dmem_bus.dmem_addr, dmem_bus.dmem_wen, dmem_bus.dmem_wdata, dmem_bus.dmem_wmask}, req_q[0]);
        if (dmem_bus.dmem_req_ready) void'(req_q.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    logic [144:0] act;
    act = {wb_alu_result, wb_mem_data, wb_byte_enable, wb_mem_to_reg, wb_mem_ext_un,
           wb_rd_waddr, wb_rd_wena, wb_misalign};
    if (reset_n && act != '0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got %h with nothing expected", act);
      end else begin
        chk("wb_record", act, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model for one op ----------------
  function automatic int acc_size(input logic [7:0] be);
    case (be)
      8'h03:   return 2;
      8'h0F:   return 4;
      8'hFF:   return 8;
      default: return 1;
    endcase
  endfunction

  task automatic model_op(input bit ren, input bit wen, input bit ext, input logic [63:0] alu,
                          input logic [63:0] wdata, input logic [7:0] be, input logic [4:0] rd,
                          input bit wena, output logic [144:0] rec, output bit issued);
    bit          mem_op;
    bit          mis;
    int          off;
    logic [63:0] base;
    logic [7:0]  mask;
    logic [63:0] mdata;
    mem_op = ren | wen;
    off = int'(alu[2:0]);
    base = alu - 64'(off);
    mis = mem_op && ((alu % 64'(acc_size(be))) != 0);
    issued = mem_op && !(misalign_chk && mis);
    if (!mem_op) begin
      rec = {alu, 64'd0, be, 1'b0, ext, rd, wena, 1'b0};
    end else if (!issued) begin
      rec = {alu, 64'd0, be, ren, ext, rd, 1'b0, 1'b1};
    end else begin
      mask = '0;
      mdata = '0;
      for (int k = 0; k < 8; k++)
        if (be[k] && (off + k) < 8) mask[off + k] = 1'b1;
      if (ren) begin
        mdata = ref_dword(base);
        mask = '0;
      end else begin
        for (int k = 0; k < 8; k++)
          if (be[k] && (off + k) < 8) ref_mem[alu + 64'(k)] = wdata[8*k +: 8];
      end
      req_q.push_back({base, wen, wdata << (8 * off), mask});
      rec = {alu, mdata, be, ren, ext, rd, wena, 1'b0};
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_ex(input bit v, input bit ren, input bit wen, input bit ext,
                          input logic [63:0] alu, input logic [63:0] wdata,
                          input logic [7:0] be, input logic [4:0] rd, input bit wena);
    ex_valid = v;
    ex_mem_ren = ren;
    ex_mem_wen = wen;
    ex_mem_ext_un = ext;
    ex_alu_result = alu;
    ex_wdata = wdata;
    ex_byte_enable = be;
    ex_rd_waddr = rd;
    ex_rd_wena = wena;
  endtask

  task automatic issue(input bit ren, input bit wen, input bit ext, input logic [63:0] alu,
                       input logic [63:0] wdata, input logic [7:0] be, input logic [4:0] rd,
                       input bit wena, input int rdy, input int rsp);
    logic [144:0] rec;
    bit           issued;
    int           stalls;
    model_op(ren, wen, ext, alu, wdata, be, rd, wena, rec, issued);
    exp_q.push_back(rec);
    cfg_rdy = rdy;
    cfg_rsp = rsp;
    drive_ex(1'b1, ren, wen, ext, alu, wdata, be, rd, wena);
    stalls = 0;
    forever begin
      @(negedge clock);
      if (mem_stall) begin
        stalls++;
        if (stalls > 100) begin
          total++;
          bad++;
          $display("FAIL stall_timeout: got %0d stall cycles, bound 100", stalls);
          break;
        end
        @(posedge clock);
        #1;
      end else begin
        @(posedge clock);
        #1;
        break;
      end
    end
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    chk("stall_cycles", stalls, issued ? (2 + rdy + rsp) : 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [144:0] dummy_rec;
    bit           dummy_iss;

    // reset state
    #3;
    chk("reset_outputs", {mem_stall, dmem_bus.dmem_req_valid, dmem_bus.dmem_addr, dmem_bus.dmem_wen,
                          dmem_bus.dmem_wdata, dmem_bus.dmem_wmask, wb_rd_wena, wb_misalign}, '0);
    chk("reset_wb", {wb_alu_result, wb_mem_data, wb_byte_enable, wb_mem_to_reg, wb_mem_ext_un, wb_rd_waddr}, '0);
    chk("reset_state", dbg_state, 2'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // non-memory op
    issue(1'b0, 1'b0, 1'b0, 64'h1234, 64'h0, 8'hFF, 5'd5, 1'b1, 0, 0);

    // LW at 0x80000004, full doubleword returned to WB
    poke(64'h8000_0000, 64'hDEADBEEF_00000000);
    issue(1'b1, 1'b0, 1'b0, 64'h8000_0004, 64'h0, 8'h0F, 5'd7, 1'b1, 0, 0);

    // SH 0xABCD at 0x80000006 with ready held low for 3 cycles
    issue(1'b0, 1'b1, 1'b0, 64'h8000_0006, 64'hABCD, 8'h03, 5'd0, 1'b0, 3, 0);

    // doubleword at an offset of 4: trapped with the check, truncated without
    issue(1'b1, 1'b0, 1'b0, 64'h8000_0004, 64'h0, 8'hFF, 5'd9, 1'b1, 0, 1);
    issue(1'b0, 1'b1, 1'b0, 64'h8000_0004, 64'h1122334455667788, 8'hFF, 5'd0, 1'b0, 1, 0);
    issue(1'b1, 1'b0, 1'b1, 64'h8000_0000, 64'h0, 8'hFF, 5'd10, 1'b1, 0, 0);

    // randomized mix of ALU ops, loads and stores with bubbles and bus delays
    for (int i = 0; i < 80; i++) begin
      int          kind;
      int          sz;
      int          off;
      logic [7:0]  be;
      logic [63:0] addr;
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: be = 8'h01;
        1: be = 8'h03;
        2: be = 8'h0F;
        default: be = 8'hFF;
      endcase
      sz = acc_size(be);
      if ($urandom_range(0, 3) == 0) off = $urandom_range(0, 7);
      else off = sz * $urandom_range(0, (8 / sz) - 1);
      addr = 64'h8000_0000 + 64'($urandom_range(0, 15) * 8) + 64'(off);
      case (kind)
        0: issue(1'b0, 1'b0, 1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)} | 64'd1,
                 64'h0, be, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 0);
        1: issue(1'b1, 1'b0, 1'($urandom_range(0, 1)), addr, 64'h0, be,
                 5'($urandom_range(0, 31)), 1'b1, $urandom_range(0, 3), $urandom_range(0, 3));
        default: issue(1'b0, 1'b1, 1'b0, addr, {32'($urandom), 32'($urandom)}, be,
                       5'd0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clock);
        #1;
      end
    end

    // reset while waiting for a response; the response then arrives in IDLE
    cfg_rdy = 0;
    cfg_rsp = 6;
    model_op(1'b1, 1'b0, 1'b0, 64'h8000_0040, 64'h0, 8'hFF, 5'd3, 1'b1, dummy_rec, dummy_iss);
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0040, 64'h0, 8'hFF, 5'd3, 1'b1);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    chk("pre_reset_state", dbg_state, 2'd2);
    chk("pre_reset_stall", mem_stall, 1'b1);
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_req_valid", dmem_bus.dmem_req_valid, 1'b0);
    chk("mid_reset_state", dbg_state, 2'd0);
    chk("mid_reset_outputs", {mem_stall, dmem_bus.dmem_addr, dmem_bus.dmem_wen, dmem_bus.dmem_wmask,
                              wb_alu_result, wb_rd_wena, wb_mem_to_reg}, '0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("post_reset_state", dbg_state, 2'd0);
      chk("post_reset_stall", mem_stall, 1'b0);
      chk("post_reset_wena", wb_rd_wena, 1'b0);
    end
    @(posedge clock);
    #1;

    // recovery after reset
    issue(1'b0, 1'b1, 1'b0, 64'h8000_0010, 64'h55AA, 8'h03, 5'd0, 1'b0, 0, 0);
    issue(1'b1, 1'b0, 1'b1, 64'h8000_0010, 64'h0, 8'h03, 5'd4, 1'b1, 2, 2);
    issue(1'b0, 1'b0, 1'b0, 64'h42, 64'h0, 8'h01, 5'd31, 1'b1, 0, 0);

    repeat (3) @(posedge clock);
    #1;
    chk("wb_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
